// File: rtl/uart_txfifo_bridge.sv
// CPU-facing TX FIFO in front of the CPLD UART adapter: queues console bytes, polls adapter
// status and drains when ready, and serialises CPU RX reads. Optional flush via UART_TXFIFO_FLUSH_EN.
module uart_txfifo_bridge #(
    parameter int DEPTH_LOG2      = 4,
    parameter int WR_PULSE_CYCLES = 2,
    parameter int RD_PULSE_CYCLES = 2,
    parameter int POLL_GUARD      = 4
) (
    input  logic        clk_bus,
    input  logic        rst_n,
    input  logic [3:0]  cpu_address,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic        cpu_stall,
    output logic [3:0]  uart_address,
    output logic [31:0] uart_data_o,
    input  logic [31:0] uart_data_i,
    output logic        uart_read,
    output logic        uart_write
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [7:0]    WR_LAST  = 8'(WR_PULSE_CYCLES - 1);
    localparam logic [7:0]    RD_LAST  = 8'(RD_PULSE_CYCLES - 1);
    localparam logic [7:0]    GD_LAST  = 8'(POLL_GUARD - 1);

    typedef enum logic [2:0] {S_IDLE, S_POLL, S_WRITE, S_GUARD, S_RXRD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          tsre_last_q, tsre_last_d;
    logic          rx_pending_q, rx_pending_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          uart_read_q, uart_read_d;
    logic          uart_write_q, uart_write_d;
    logic [3:0]    uart_address_q, uart_address_d;
    logic [31:0]   uart_data_q, uart_data_d;
    logic [7:0]    mem_q [DEPTH];

    logic          full, empty, pop, push_ok, flush, rx_done;
    logic          addr_tx, addr_st;
    logic [PW-1:0] count;
    logic [31:0]   status;
    logic          unused_bits;

    assign unused_bits = ^{cpu_data_i[31:8], uart_data_i[31:8]};

    assign addr_tx = (cpu_address == 4'h8);
    assign addr_st = (cpu_address == 4'hC);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    // bit1/bit0 mimic the adapter's tready/tsre so existing polling code still works
    assign status  = {16'h0, 8'(count), 5'b0, overflow_q, ~full, empty & tsre_last_q};

`ifdef UART_TXFIFO_FLUSH_EN
    assign flush = cpu_write && (cpu_address == 4'h4) && cpu_data_i[0];
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tsre_last_d    = tsre_last_q;
        rx_valid_d     = 1'b0;
        rx_byte_d      = rx_byte_q;
        uart_read_d    = uart_read_q;
        uart_write_d   = uart_write_q;
        uart_address_d = uart_address_q;
        uart_data_d    = uart_data_q;
        pop            = 1'b0;
        rx_done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (rx_pending_q) begin
                    state_d        = S_RXRD;
                    uart_read_d    = 1'b1;
                    uart_address_d = 4'h8;
                end else if (!empty) begin
                    state_d        = S_POLL;
                    uart_read_d    = 1'b1;
                    uart_address_d = 4'hC;
                end
            end
            S_POLL: begin
                tsre_last_d = uart_data_i[0];
                uart_read_d = 1'b0;
                cnt_d       = 8'd0;
                if (uart_data_i[1] && !empty) begin
                    pop            = 1'b1;
                    uart_data_d    = {24'h0, mem_q[rd_ptr_q[PW-2:0]]};
                    uart_write_d   = 1'b1;
                    uart_address_d = 4'h8;
                    state_d        = S_WRITE;
                end else begin
                    uart_address_d = 4'h0;
                    state_d        = S_IDLE;
                end
            end
            S_WRITE: begin
                if (cnt_q == WR_LAST) begin
                    uart_write_d   = 1'b0;
                    uart_address_d = 4'h0;
                    cnt_d          = 8'd0;
                    state_d        = S_GUARD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GUARD: begin
                // lets the adapter's synchronised tready settle before the next poll
                if (cnt_q == GD_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RXRD: begin
                if (cnt_q == RD_LAST) begin
                    rx_byte_d      = uart_data_i[7:0];
                    rx_valid_d     = 1'b1;
                    rx_done        = 1'b1;
                    uart_read_d    = 1'b0;
                    uart_address_d = 4'h0;
                    cnt_d          = 8'd0;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_pending_d = rx_pending_q;
        if (rx_done)
            rx_pending_d = 1'b0;
        else if (cpu_read && addr_tx && !rx_valid_q)
            rx_pending_d = 1'b1;

        push_ok  = cpu_write && addr_tx && (!full || pop) && !flush;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        if (flush)
            rd_ptr_d = wr_ptr_q;

        overflow_d = overflow_q;
        if (cpu_write && addr_tx && full && !pop && !flush)
            overflow_d = 1'b1;
        else if ((cpu_read && addr_st) || flush)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk_bus) begin
        if (push_ok)
            mem_q[wr_ptr_q[PW-2:0]] <= cpu_data_i[7:0];
    end

    always_ff @(posedge clk_bus) begin
        rx_byte_q   <= rx_byte_d;
        uart_data_q <= uart_data_d;
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            overflow_q     <= 1'b0;
            tsre_last_q    <= 1'b1;
            rx_pending_q   <= 1'b0;
            rx_valid_q     <= 1'b0;
            uart_read_q    <= 1'b0;
            uart_write_q   <= 1'b0;
            uart_address_q <= 4'h0;
            uart_data_q    <= 32'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            overflow_q     <= overflow_d;
            tsre_last_q    <= tsre_last_d;
            rx_pending_q   <= rx_pending_d;
            rx_valid_q     <= rx_valid_d;
            uart_read_q    <= uart_read_d;
            uart_write_q   <= uart_write_d;
            uart_address_q <= uart_address_d;
        end
    end

    always_comb begin
        cpu_data_o = 32'h0;
        if (rst_n && cpu_read) begin
            if (addr_st)
                cpu_data_o = status;
            else if (addr_tx && rx_valid_q)
                cpu_data_o = {24'h0, rx_byte_q};
        end
    end

    assign cpu_stall    = rst_n && cpu_read && addr_tx && !rx_valid_q;
    assign uart_read    = uart_read_q;
    assign uart_write   = uart_write_q;
    assign uart_address = uart_address_q;
    assign uart_data_o  = uart_data_q;
endmodule

// File: tb/tb_uart_txfifo_bridge.sv
// Directed bench for uart_txfifo_bridge with a combinational adapter model; checks the
// flush path when UART_TXFIFO_FLUSH_EN is defined, the ignored 0x4 write otherwise.
module tb_uart_txfifo_bridge;
    logic        clk_bus = 1'b0;
    logic        rst_n;
    logic [3:0]  cpu_address;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_stall;
    logic [3:0]  uart_address;
    logic [31:0] uart_data_o;
    logic [31:0] uart_data_i;
    logic        uart_read;
    logic        uart_write;

    logic        tready;
    logic        tsre;
    int          checks = 0;
    int          failures = 0;
    int          write_cycles = 0;
    logic        wr_prev = 1'b0;
    logic [7:0]  tx_log[$];

    uart_txfifo_bridge dut (
        .clk_bus      (clk_bus),
        .rst_n        (rst_n),
        .cpu_address  (cpu_address),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_stall    (cpu_stall),
        .uart_address (uart_address),
        .uart_data_o  (uart_data_o),
        .uart_data_i  (uart_data_i),
        .uart_read    (uart_read),
        .uart_write   (uart_write)
    );

    always #5 clk_bus = ~clk_bus;

    // Adapter model: status at 0xC, RX byte 0x5A (upper bits junk) at 0x8
    assign uart_data_i = (uart_address == 4'hC) ? {30'h0, tready, tsre} :
                         (uart_address == 4'h8) ? 32'hFFFF_FF5A : 32'h0;

    always @(posedge clk_bus) begin
        if (uart_write && !wr_prev)
            tx_log.push_back(uart_data_o[7:0]);
        if (uart_write)
            write_cycles <= write_cycles + 1;
        wr_prev <= uart_write;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_bus);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
        cpu_address = a;
        cpu_data_i  = d;
        cpu_write   = 1'b1;
        tick(1);
        cpu_write   = 1'b0;
        cpu_address = 4'h0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        cpu_address = 4'hC;
        cpu_read    = 1'b1;
        #1;
        check(tag, cpu_data_o, exp);
        tick(1);
        cpu_read    = 1'b0;
        cpu_address = 4'h0;
    endtask

    initial begin
        int base;
        int n;
        rst_n = 1'b0; cpu_address = 4'h8; cpu_data_i = 32'h0;
        cpu_read = 1'b1; cpu_write = 1'b0; tready = 1'b1; tsre = 1'b1;
        tick(3);
        check("rst_stall", {31'h0, cpu_stall}, 32'h0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        check("rst_uart_write", {31'h0, uart_write}, 32'h0);
        check("rst_uart_read", {31'h0, uart_read}, 32'h0);
        check("rst_uart_addr", {28'h0, uart_address}, 32'h0);
        check("rst_uart_data", uart_data_o, 32'h0);
        cpu_read = 1'b0; cpu_address = 4'h0; rst_n = 1'b1;
        tick(1);
        chk_status("status_idle", 32'h0000_0003);

        // single byte: poll one cycle after push, write two cycles later
        base = write_cycles;
        cpu_wr(4'h8, 32'hFFFF_FF41);
        check("t1_no_read_yet", {31'h0, uart_read}, 32'h0);
        tick(1);
        check("t1_poll_read", {31'h0, uart_read}, 32'h1);
        check("t1_poll_addr", {28'h0, uart_address}, 32'hC);
        tick(1);
        check("t1_write_hi", {31'h0, uart_write}, 32'h1);
        check("t1_write_data", uart_data_o, 32'h0000_0041);
        check("t1_write_addr", {28'h0, uart_address}, 32'h8);
        tick(1);
        check("t1_write_hold", {31'h0, uart_write}, 32'h1);
        tick(1);
        check("t1_write_lo", {31'h0, uart_write}, 32'h0);
        check("t1_addr_idle", {28'h0, uart_address}, 32'h0);
        check("t1_pulse_len", write_cycles - base, 32'd2);
        chk_status("t1_empty", 32'h0000_0003);
        tick(6);

        // overflow with adapter not ready
        tready = 1'b0;
        for (int i = 0; i < 17; i++) cpu_wr(4'h8, 32'h60 + i);
        chk_status("t2_ovf_status", 32'h0000_1004);
        chk_status("t2_ovf_cleared", 32'h0000_1000);

        // drain in order once tready rises
        tx_log.delete();
        base = write_cycles;
        tick(20);
        check("t3_no_early_write", tx_log.size(), 32'd0);
        check("t3_no_early_cycles", write_cycles - base, 32'd0);
        tready = 1'b1;
        tick(200);
        check("t3_drained_count", tx_log.size(), 32'd16);
        for (int i = 0; i < 16 && i < tx_log.size(); i++)
            check($sformatf("t3_byte%0d", i), {24'h0, tx_log[i]}, 32'h60 + i);
        check("t3_pulse_total", write_cycles - base, 32'd32);
        chk_status("t3_empty", 32'h0000_0003);

        // RX read interleaved with TX drain
        tx_log.delete();
        cpu_wr(4'h8, 32'h11);
        cpu_wr(4'h8, 32'h22);
        cpu_wr(4'h8, 32'h33);
        tick(3);
        cpu_address = 4'h8;
        cpu_read = 1'b1;
        #1;
        check("t4_stall_start", {31'h0, cpu_stall}, 32'h1);
        n = 0;
        while (cpu_stall === 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
        check("t4_rx_in_time", {31'h0, n < 60}, 32'h1);
        check("t4_stall_min", {31'h0, n >= 3}, 32'h1);
        check("t4_rx_data", cpu_data_o, 32'h0000_005A);
        cpu_read = 1'b0;
        cpu_address = 4'h0;
        tick(100);
        check("t4_tx_count", tx_log.size(), 32'd3);
        if (tx_log.size() == 3) begin
            check("t4_tx0", {24'h0, tx_log[0]}, 32'h11);
            check("t4_tx1", {24'h0, tx_log[1]}, 32'h22);
            check("t4_tx2", {24'h0, tx_log[2]}, 32'h33);
        end

        // reset in the middle of a write pulse
        cpu_wr(4'h8, 32'h77);
        cpu_wr(4'h8, 32'h78);
        n = 0;
        while (uart_write !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        check("t5_write_seen", {31'h0, uart_write}, 32'h1);
        rst_n = 1'b0;
        tick(1);
        check("t5_write_abort", {31'h0, uart_write}, 32'h0);
        check("t5_addr_abort", {28'h0, uart_address}, 32'h0);
        rst_n = 1'b1;
        tick(4);
        check("t5_no_poll", {31'h0, uart_read}, 32'h0);
        chk_status("t5_empty", 32'h0000_0003);

        // flush (or ignored write to 0x4)
        tready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_wr(4'h8, 32'h90 + i);
        base = write_cycles;
        cpu_wr(4'h4, 32'h1);
`ifdef UART_TXFIFO_FLUSH_EN
        chk_status("t6_flushed", 32'h0000_0003);
`else
        chk_status("t6_ignored", 32'h0000_0502);
`endif
        tick(20);
        check("t6_no_write", write_cycles - base, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
